// File: rtl/mem_arbiter_pkg.sv
// Shared types, constants and address-decode helpers for the mem arbiter.
package mem_arbiter_pkg;

    // Default start of the memory-mapped I/O window.
    localparam logic [31:0] MMIO_BASE = 32'hC000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        ACK   = 2'd2
    } arb_state_t;

    // Word accesses only: any set bit in the two low address bits is refused.
    function automatic logic misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

    // Addresses are widened to 64 bits so the helper works for any WIDTH up to 64.
    function automatic logic is_mmio(input logic [63:0] addr, input logic [63:0] base);
        return addr >= base;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker; the requester not served last wins a tie.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // last = 1 means port 1 was served most recently, so port 0 wins a tie.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the single-port mem block between the CPU (port 0)
// and the debug/program-loader port (port 1). Each access is latched in IDLE,
// driven onto mem for one SERVE cycle and acknowledged in ACK.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] MMIO_BASE = WIDTH'(mem_arbiter_pkg::MMIO_BASE)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req0,
    input  logic             req1,
    input  logic             we0,
    input  logic             we1,
    input  logic [WIDTH-1:0] addr0,
    input  logic [WIDTH-1:0] addr1,
    input  logic [WIDTH-1:0] wdata0,
    input  logic [WIDTH-1:0] wdata1,
    output logic             ack0,
    output logic             ack1,
    output logic             err0,
    output logic             err1,
    output logic [WIDTH-1:0] rdata0,
    output logic [WIDTH-1:0] rdata1,
    output logic [WIDTH-1:0] mem_a,
    output logic [WIDTH-1:0] mem_wd,
    output logic             mem_we,
    input  logic [WIDTH-1:0] mem_rd
);

    arb_state_t       state;
    logic             last;
    logic             lat_port;
    logic             lat_we;
    logic             lat_ref;
    logic [WIDTH-1:0] lat_addr;
    logic [WIDTH-1:0] lat_wdata;

    logic [1:0]       gnt;
    logic             sel_port;
    logic             sel_we;
    logic [WIDTH-1:0] sel_addr;
    logic [WIDTH-1:0] sel_wdata;
    logic             sel_ref;

    rr_pick2 u_pick (
        .req  ({req1, req0}),
        .last (last),
        .gnt  (gnt)
    );

    // Select the granted port's request and decide refusal before it is latched.
    always_comb begin
        sel_port  = gnt[1];
        sel_we    = gnt[1] ? we1    : we0;
        sel_addr  = gnt[1] ? addr1  : addr0;
        sel_wdata = gnt[1] ? wdata1 : wdata0;
        sel_ref   = misaligned(sel_addr[1:0]) ||
                    (sel_port && sel_we && is_mmio(64'(sel_addr), 64'(MMIO_BASE)));
    end

    // FSM, request latch and read-data capture; reset drops any in-flight access.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            last      <= 1'b1;
            lat_port  <= 1'b0;
            lat_we    <= 1'b0;
            lat_ref   <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rdata0    <= '0;
            rdata1    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt != 2'b00) begin
                        lat_port  <= sel_port;
                        lat_we    <= sel_we;
                        lat_ref   <= sel_ref;
                        lat_addr  <= sel_addr;
                        lat_wdata <= sel_wdata;
                        state     <= SERVE;
                    end
                end
                SERVE: begin
                    if (!lat_we && !lat_ref) begin
                        if (lat_port) rdata1 <= mem_rd;
                        else          rdata0 <= mem_rd;
                    end
                    last  <= lat_port;
                    state <= ACK;
                end
                ACK:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // mem bus follows the latch at all times; a write strobe only in SERVE and never when refused.
    assign mem_a  = lat_addr;
    assign mem_wd = lat_wdata;
    assign mem_we = (state == SERVE) && lat_we && !lat_ref;

    // Acks decode from the ACK state, so only the granted port can see one.
    assign ack0 = (state == ACK) && !lat_port;
    assign ack1 = (state == ACK) &&  lat_port;
    assign err0 = ack0 && lat_ref;
    assign err1 = ack1 && lat_ref;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a small read-only mem model.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        ack0, ack1, err0, err1;
    logic [31:0] rdata0, rdata1, mem_a, mem_wd, mem_rd;
    logic        mem_we;

    logic [31:0] tbmem [0:15];
    int          checks = 0;
    int          errors = 0;
    int          weCount = 0;
    int          ack0Count = 0;
    int          bothCount = 0;
    logic [31:0] lastWa = '0;
    logic [31:0] lastWd = '0;

    mem_arbiter dut (
        .clk    (clk),
        .reset_n(reset_n),
        .req0   (req0),
        .req1   (req1),
        .we0    (we0),
        .we1    (we1),
        .addr0  (addr0),
        .addr1  (addr1),
        .wdata0 (wdata0),
        .wdata1 (wdata1),
        .ack0   (ack0),
        .ack1   (ack1),
        .err0   (err0),
        .err1   (err1),
        .rdata0 (rdata0),
        .rdata1 (rdata1),
        .mem_a  (mem_a),
        .mem_wd (mem_wd),
        .mem_we (mem_we),
        .mem_rd (mem_rd)
    );

    always #5 clk = ~clk;

    // Asynchronous-read mem model indexed by word address.
    assign mem_rd = tbmem[mem_a[5:2]];

    // Bus monitors: committed writes, port-0 acks, and any double ack.
    always @(posedge clk) begin
        if (mem_we) begin
            weCount <= weCount + 1;
            lastWa  <= mem_a;
            lastWd  <= mem_wd;
        end
        if (ack0) ack0Count <= ack0Count + 1;
        if (ack0 && ack1) bothCount <= bothCount + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        step();
        step();
        checks++;
        if ({ack0, ack1, err0, err1, mem_we} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl got %b want 00000", {ack0, ack1, err0, err1, mem_we});
        end
        checks++;
        if ({mem_a, mem_wd, rdata0, rdata1} !== 128'h0) begin
            errors++;
            $display("[TB] FAIL reset_data got %h %h %h %h want 0", mem_a, mem_wd, rdata0, rdata1);
        end
        checks++;
        if (dut.state !== IDLE || dut.last !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_state got state=%0d last=%b want 0 1", dut.state, dut.last);
        end
        reset_n = 1'b1;
        req0 = 1; we0 = 0; addr0 = 32'h10;
        step();
        checks++;
        if (ack0 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL first_latency ack0 at t+1 got %b want 0", ack0);
        end
        step();
        checks++;
        if (ack0 !== 1'b1 || err0 !== 1'b0 || rdata0 !== 32'hDEAD_BEEF) begin
            errors++;
            $display("[TB] FAIL first_read got ack0=%b err0=%b rdata0=%h want 1 0 deadbeef", ack0, err0, rdata0);
        end
        req0 = 0;
        step();
    endtask

    task automatic test_tie_alternation();
        logic expA0, expA1;
        doReset();
        req0 = 1; we0 = 0; addr0 = 32'h10;
        req1 = 1; we1 = 0; addr1 = 32'h14;
        for (int c = 1; c <= 11; c++) begin
            step();
            expA0 = (c == 2) || (c == 8);
            expA1 = (c == 5) || (c == 11);
            checks++;
            if (ack0 !== expA0 || ack1 !== expA1) begin
                errors++;
                $display("[TB] FAIL tie_cycle%0d got ack0=%b ack1=%b want %b %b", c, ack0, ack1, expA0, expA1);
            end
            if (c == 5) begin
                checks++;
                if (rdata1 !== 32'hCAFE_F00D) begin
                    errors++;
                    $display("[TB] FAIL tie_rdata1 got %h want cafef00d", rdata1);
                end
            end
        end
        req0 = 0; req1 = 0;
        step();
    endtask

    task automatic test_mmio_write();
        int w0;
        w0 = weCount;
        req1 = 1; we1 = 1; addr1 = 32'hC000_0000; wdata1 = 32'hFF;
        step();
        step();
        checks++;
        if (ack1 !== 1'b1 || err1 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL p1_mmio_refused got ack1=%b err1=%b want 1 1", ack1, err1);
        end
        req1 = 0; we1 = 0;
        step();
        checks++;
        if (weCount !== w0) begin
            errors++;
            $display("[TB] FAIL p1_mmio_no_write got %0d writes want 0", weCount - w0);
        end
        req0 = 1; we0 = 1; addr0 = 32'hC000_0000; wdata0 = 32'hFF;
        step();
        checks++;
        if (mem_we !== 1'b1 || mem_a !== 32'hC000_0000 || mem_wd !== 32'hFF) begin
            errors++;
            $display("[TB] FAIL p0_mmio_bus got we=%b a=%h wd=%h want 1 c0000000 ff", mem_we, mem_a, mem_wd);
        end
        step();
        checks++;
        if (ack0 !== 1'b1 || err0 !== 1'b0 || mem_we !== 1'b0) begin
            errors++;
            $display("[TB] FAIL p0_mmio_ack got ack0=%b err0=%b we=%b want 1 0 0", ack0, err0, mem_we);
        end
        req0 = 0; we0 = 0;
        step();
        checks++;
        if (weCount !== w0 + 1 || lastWa !== 32'hC000_0000 || lastWd !== 32'hFF) begin
            errors++;
            $display("[TB] FAIL p0_mmio_once got %0d writes a=%h wd=%h want 1 c0000000 ff", weCount - w0, lastWa, lastWd);
        end
    endtask

    task automatic test_misaligned();
        int w0;
        req0 = 1; we0 = 0; addr0 = 32'h10;
        step();
        step();
        req0 = 0;
        step();
        w0 = weCount;
        req0 = 1; we0 = 0; addr0 = 32'h6;
        step();
        step();
        checks++;
        if (ack0 !== 1'b1 || err0 !== 1'b1 || rdata0 !== 32'hDEAD_BEEF) begin
            errors++;
            $display("[TB] FAIL misaligned got ack0=%b err0=%b rdata0=%h want 1 1 deadbeef", ack0, err0, rdata0);
        end
        req0 = 0;
        step();
        checks++;
        if (weCount !== w0) begin
            errors++;
            $display("[TB] FAIL misaligned_no_write got %0d writes want 0", weCount - w0);
        end
    endtask

    task automatic test_reset_mid_access();
        req1 = 1; we1 = 1; addr1 = 32'h20; wdata1 = 32'h55;
        step();
        checks++;
        if (mem_we !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_serve_we got %b want 1", mem_we);
        end
        reset_n = 1'b0;
        req1 = 0; we1 = 0;
        step();
        checks++;
        if (mem_we !== 1'b0 || ack1 !== 1'b0 || dut.last !== 1'b1 || dut.state !== IDLE) begin
            errors++;
            $display("[TB] FAIL mid_reset got we=%b ack1=%b last=%b state=%0d want 0 0 1 0", mem_we, ack1, dut.last, dut.state);
        end
        step();
        checks++;
        if (ack1 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_no_ack got ack1=%b want 0", ack1);
        end
        reset_n = 1'b1;
        req0 = 1; we0 = 0; addr0 = 32'h10;
        req1 = 1; we1 = 0; addr1 = 32'h14;
        step();
        step();
        checks++;
        if (ack0 !== 1'b1 || ack1 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL post_reset_tie got ack0=%b ack1=%b want 1 0", ack0, ack1);
        end
        req0 = 0; req1 = 0;
        step();
        step();
        step();
    endtask

    task automatic test_back_to_back();
        int a0;
        a0 = ack0Count;
        req0 = 1; we0 = 0; addr0 = 32'h10;
        step();
        step();
        checks++;
        if (ack0 !== 1'b1 || rdata0 !== 32'hDEAD_BEEF) begin
            errors++;
            $display("[TB] FAIL b2b_first got ack0=%b rdata0=%h want 1 deadbeef", ack0, rdata0);
        end
        addr0 = 32'h14;
        step();
        checks++;
        if (ack0 !== 1'b0 || dut.state !== IDLE) begin
            errors++;
            $display("[TB] FAIL b2b_idle got ack0=%b state=%0d want 0 0", ack0, dut.state);
        end
        step();
        checks++;
        if (ack0 !== 1'b0 || dut.state !== SERVE) begin
            errors++;
            $display("[TB] FAIL b2b_serve got ack0=%b state=%0d want 0 1", ack0, dut.state);
        end
        step();
        checks++;
        if (ack0 !== 1'b1 || rdata0 !== 32'hCAFE_F00D) begin
            errors++;
            $display("[TB] FAIL b2b_second got ack0=%b rdata0=%h want 1 cafef00d", ack0, rdata0);
        end
        req0 = 0;
        step();
        step();
        checks++;
        if (ack0Count - a0 !== 2) begin
            errors++;
            $display("[TB] FAIL b2b_ack_count got %0d want 2", ack0Count - a0);
        end
    endtask

    // Scenario sequence, followed by the global no-double-ack check and summary.
    initial begin
        for (int i = 0; i < 16; i++) tbmem[i] = 32'h1000_0000 + i;
        tbmem[1] = 32'h1234_5678;
        tbmem[4] = 32'hDEAD_BEEF;
        tbmem[5] = 32'hCAFE_F00D;
        test_reset();
        test_tie_alternation();
        test_mmio_write();
        test_misaligned();
        test_reset_mid_access();
        test_back_to_back();
        checks++;
        if (bothCount !== 0) begin
            errors++;
            $display("[TB] FAIL double_ack got %0d cycles want 0", bothCount);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
